axis_pkt_arbiter: RTL and testbench

AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

---
 rtl/axis_pkt_arbiter.sv | 111 +++++++++++
 tb/tb_axis_pkt_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS AXI4-Stream requesters onto one stream.
// A grant is locked from the arbitration cycle until the granted port's tlast is accepted.
module axis_pkt_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PORTS  = 4,
    localparam int IDW       = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            grant_valid,
    output logic [IDW-1:0]                  grant_id,
    output logic                            beat_accept,
    output logic [31:0]                     pkt_count
);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [31:0]    pkt_count_q, pkt_count_d;

    logic           rr_hit;
    logic [IDW-1:0] rr_pick;
    logic [IDW-1:0] rr_idx;
    logic           in_xfer;

    // First requester after last_grant, wrapping around.
    always_comb begin
        rr_hit  = 1'b0;
        rr_pick = '0;
        rr_idx  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            rr_idx = IDW'((int'(last_grant_q) + k) % NUM_PORTS);
            if (!rr_hit && s_axis_tvalid[rr_idx]) begin
                rr_hit  = 1'b1;
                rr_pick = rr_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= IDW'(NUM_PORTS - 1);
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        pkt_count_d  = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (rr_hit) begin
                    grant_id_d = rr_pick;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (beat_accept && m_axis_tlast) begin
                    state_d      = IDLE;
                    last_grant_d = grant_id_q;
                    pkt_count_d  = pkt_count_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are also gated by rst so nothing handshakes during the reset cycle itself.
    always_comb begin
        in_xfer       = (state_q == XFER) && !rst;
        grant_valid   = in_xfer;
        m_axis_tvalid = in_xfer && s_axis_tvalid[grant_id_q];
        m_axis_tlast  = in_xfer && s_axis_tlast[grant_id_q];
        m_axis_tdata  = in_xfer ? s_axis_tdata[grant_id_q*DATA_WIDTH +: DATA_WIDTH] : '0;
        beat_accept   = m_axis_tvalid && m_axis_tready;
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
            assign s_axis_tready[gi] = in_xfer && (grant_id_q == IDW'(gi)) && m_axis_tready;
        end
    endgenerate

    assign grant_id  = grant_id_q;
    assign pkt_count = pkt_count_q;

`ifndef SYNTHESIS
    a_valid_needs_grant : assert property (@(posedge clk) disable iff (rst)
        !(m_axis_tvalid && !grant_valid));
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: packet-level reference model checked every cycle,
// plus directed scenarios with hand-computed grant orders, latencies and counts.
module tb_axis_pkt_arbiter;

    localparam int DW  = 64;
    localparam int NP  = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP*DW-1:0] s_axis_tdata;
    logic [NP-1:0]    s_axis_tvalid;
    logic [NP-1:0]    s_axis_tready;
    logic [NP-1:0]    s_axis_tlast;
    logic [DW-1:0]    m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic             grant_valid;
    logic [IDW-1:0]   grant_id;
    logic             beat_accept;
    logic [31:0]      pkt_count;

    always #5 clk = ~clk;

    axis_pkt_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .beat_accept   (beat_accept),
        .pkt_count     (pkt_count)
    );

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         src_q[$];
    logic [NP-1:0] hold = '0;
    int            checks = 0;
    int            fails = 0;
    bit            chk_en = 1'b0;
    bit            preload = 1'b0;
    int            cyc = 0;

    logic [DW-1:0] acc_data[$];
    int            acc_cyc[$];
    int            grant_log[$];
    logic          gv_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input int port, input int pkt, input int beat);
        return {16'h0, 16'(port), 16'(pkt), 16'(beat)};
    endfunction

    function automatic int head_idx(input int p);
        foreach (src_q[i]) if (src_q[i].port == p) return i;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: which port holds the packet grant, who won last, packets done.
    int          m_cur  = -1;
    int          m_last = NP - 1;
    int          m_gid  = 0;
    logic [31:0] m_cnt  = '0;

    always @(posedge clk) begin
        automatic int pick = -1;
        if (rst) begin
            m_cur  <= -1;
            m_last <= NP - 1;
            m_gid  <= 0;
            m_cnt  <= '0;
        end else if (m_cur < 0) begin
            for (int k = 1; k <= NP; k++)
                if (pick < 0 && s_axis_tvalid[(m_last + k) % NP]) pick = (m_last + k) % NP;
            if (pick >= 0) begin
                m_cur <= pick;
                m_gid <= pick;
            end
        end else if (s_axis_tvalid[m_cur] && m_axis_tready && s_axis_tlast[m_cur]) begin
            m_last <= m_cur;
            m_cur  <= -1;
            m_cnt  <= m_cnt + 32'd1;
        end
        if (preload) m_cnt <= 32'hFFFF_FFFF;
    end

    // Per-cycle comparison against the model, and logging of grants and accepted beats.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit            busy = (m_cur >= 0) && !rst;
            automatic logic [NP-1:0] exp_rdy = (busy && m_axis_tready) ? NP'(1 << m_cur) : '0;
            automatic logic          exp_vld = busy && s_axis_tvalid[m_cur];
            check("s_tready", s_axis_tready, exp_rdy);
            check("m_tvalid", m_axis_tvalid, exp_vld);
            check("grant_valid", grant_valid, busy);
            check("beat_accept", beat_accept, exp_vld && m_axis_tready);
            check("grant_id", grant_id, m_gid);
            check("pkt_count", pkt_count, m_cnt);
            if (busy) begin
                check("m_tdata", m_axis_tdata, s_axis_tdata[m_cur*DW +: DW]);
                check("m_tlast", m_axis_tlast, s_axis_tlast[m_cur]);
            end
            if (beat_accept) begin
                acc_data.push_back(m_axis_tdata);
                acc_cyc.push_back(cyc);
            end
            if (grant_valid && !gv_prev) grant_log.push_back(int'(grant_id));
            gv_prev = grant_valid;
        end
    end

    // Source model: each port presents the head of its packet queue, popped on handshake.
    initial begin
        logic [NP-1:0] fire;
        int h;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        forever begin
            @(negedge clk);
            fire = s_axis_tvalid & s_axis_tready;
            @(posedge clk);
            #2;
            for (int p = 0; p < NP; p++) begin
                if (fire[p]) begin
                    h = head_idx(p);
                    if (h >= 0) src_q.delete(h);
                end
            end
            for (int p = 0; p < NP; p++) begin
                h = head_idx(p);
                if (h >= 0) begin
                    s_axis_tdata[p*DW +: DW] = src_q[h].data;
                    s_axis_tlast[p]          = src_q[h].last;
                    s_axis_tvalid[p]         = !hold[p];
                end else begin
                    s_axis_tdata[p*DW +: DW] = '0;
                    s_axis_tlast[p]          = 1'b0;
                    s_axis_tvalid[p]         = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_pkt(input int port, input int pkt, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            beat_t bt;
            bt.port = port;
            bt.data = mkdata(port, pkt, b);
            bt.last = (b == nbeats - 1);
            src_q.push_back(bt);
        end
    endtask

    task automatic clear_logs();
        acc_data.delete();
        acc_cyc.delete();
        grant_log.delete();
    endtask

    task automatic wait_cnt(input logic [31:0] target, input int budget, input string name);
        int n = 0;
        while (pkt_count !== target && n < budget) begin
            tick(1);
            n++;
        end
        check(name, pkt_count, target);
    endtask

    task automatic wait_beats(input int nb, input int budget, input string name);
        int n = 0;
        while (acc_data.size() < nb && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 64'(acc_data.size() >= nb), 64'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        rst           = 1'b1;
        m_axis_tready = 1'b1;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_pkt_count", pkt_count, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_s_tready", s_axis_tready, 0);
        tick(2);

        // Port 2, 3-beat packet: beats on cycles 1..3 after tvalid.
        clear_logs();
        add_pkt(2, 1, 3);
        c0 = cyc;
        wait_cnt(1, 20, "p2_pkt_count");
        tick(2);
        check("p2_grants", 64'(grant_log.size()), 1);
        if (grant_log.size() > 0) check("p2_grant_id", grant_log[0], 2);
        check("p2_nbeats", 64'(acc_data.size()), 3);
        for (int i = 0; i < acc_data.size() && i < 3; i++) begin
            check("p2_beat_cycle", acc_cyc[i] - c0, i + 1);
            check("p2_beat_data", acc_data[i], mkdata(2, 1, i));
        end
        check("p2_idle", grant_valid, 0);

        // Four ports of single-beat packets: order 0,1,2,3,0, one beat every 2 cycles.
        pulse_reset();
        clear_logs();
        add_pkt(0, 1, 1);
        add_pkt(1, 1, 1);
        add_pkt(2, 1, 1);
        add_pkt(3, 1, 1);
        add_pkt(0, 2, 1);
        wait_cnt(5, 40, "rr_pkt_count");
        tick(2);
        check("rr_grants", 64'(grant_log.size()), 5);
        for (int i = 0; i < grant_log.size() && i < 5; i++) check("rr_order", grant_log[i], i % 4);
        for (int i = 1; i < acc_cyc.size(); i++) check("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 2);
        if (acc_data.size() == 5) check("rr_last_data", acc_data[4], mkdata(0, 2, 0));

        // Port 1 with a 3-cycle downstream stall after beat 1.
        clear_logs();
        add_pkt(1, 1, 4);
        wait_beats(2, 20, "stall_start");
        m_axis_tready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_s_tready1", s_axis_tready[1], 0);
            check("stall_tdata", m_axis_tdata, mkdata(1, 1, 2));
        end
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        wait_cnt(6, 20, "stall_pkt_count");
        tick(2);
        check("stall_nbeats", 64'(acc_data.size()), 4);
        for (int i = 0; i < acc_data.size() && i < 4; i++)
            check("stall_beat_data", acc_data[i], mkdata(1, 1, i));

        // Port 0 drops tvalid mid-packet while port 3 waits.
        pulse_reset();
        clear_logs();
        add_pkt(0, 1, 4);
        add_pkt(3, 1, 1);
        wait_beats(2, 20, "gap_start");
        hold[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("gap_grant_valid", grant_valid, 1);
            check("gap_grant_id", grant_id, 0);
            check("gap_m_tvalid", m_axis_tvalid, 0);
        end
        @(posedge clk);
        #1;
        hold[0] = 1'b0;
        wait_cnt(2, 30, "gap_pkt_count");
        tick(2);
        check("gap_grants", 64'(grant_log.size()), 2);
        if (grant_log.size() == 2) begin
            check("gap_first", grant_log[0], 0);
            check("gap_second", grant_log[1], 3);
        end
        check("gap_nbeats", 64'(acc_data.size()), 5);
        if (acc_data.size() == 5) check("gap_p3_data", acc_data[4], mkdata(3, 1, 0));

        // Reset during beat 2 of a 4-beat packet on port 2.
        clear_logs();
        add_pkt(2, 1, 4);
        wait_beats(1, 20, "mid_rst_start");
        rst = 1'b1;
        src_q.delete();
        @(negedge clk);
        check("in_rst_s_tready", s_axis_tready, 0);
        check("in_rst_m_tvalid", m_axis_tvalid, 0);
        check("in_rst_grant_valid", grant_valid, 0);
        check("in_rst_beat_accept", beat_accept, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_pkt_count", pkt_count, 0);
        check("mid_rst_grant_id", grant_id, 0);
        check("mid_rst_grant_valid", grant_valid, 0);
        clear_logs();
        add_pkt(3, 2, 1);
        add_pkt(1, 2, 1);
        wait_cnt(2, 30, "post_rst_pkt_count");
        tick(2);
        check("post_rst_grants", 64'(grant_log.size()), 2);
        if (grant_log.size() == 2) begin
            check("post_rst_first", grant_log[0], 1);
            check("post_rst_second", grant_log[1], 3);
        end

        // pkt_count wrap from 0xFFFF_FFFF.
        @(negedge clk);
        #1;
        force dut.pkt_count_q = 32'hFFFF_FFFF;
        preload = 1'b1;
        @(posedge clk);
        #1;
        release dut.pkt_count_q;
        preload = 1'b0;
        check("wrap_preload", pkt_count, 32'hFFFF_FFFF);
        add_pkt(0, 3, 2);
        wait_cnt(0, 20, "wrap_pkt_count");
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
